// File: rtl/nbody_step_scheduler_if.sv
// rtl/nbody_step_scheduler_if.sv - pair/integrate request handshakes between scheduler and physics datapath
interface nbody_step_scheduler_if #(
  parameter int IDX_W = 4
);
  logic             PAIR_VALID;
  logic             PAIR_READY;
  logic [IDX_W-1:0] PAIR_I;
  logic [IDX_W-1:0] PAIR_J;
  logic             PAIR_DONE;
  logic             INT_VALID;
  logic             INT_READY;
  logic [IDX_W-1:0] INT_IDX;
  logic             INT_DONE;

  modport master (
    output PAIR_VALID, PAIR_I, PAIR_J, INT_VALID, INT_IDX,
    input  PAIR_READY, PAIR_DONE, INT_READY, INT_DONE
  );

  modport slave (
    input  PAIR_VALID, PAIR_I, PAIR_J, INT_VALID, INT_IDX,
    output PAIR_READY, PAIR_DONE, INT_READY, INT_DONE
  );
endinterface

// File: rtl/nbody_step_scheduler.sv
// rtl/nbody_step_scheduler.sv - N-body step sequencer: clear, pairwise forces, integrate, drain
// NBODY_SCHED_STATS_EN adds STEP_CYCLES (cycles from accepted START to DONE inclusive).
module nbody_step_scheduler #(
  parameter int MAX_BODIES = 10,
  parameter int IDX_W      = 4,
  parameter int OUT_W      = 7
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [6:0] NUM_BODIES,
  output logic       BUSY,
  output logic       DONE,
  output logic       CLR_ACC,
  output logic       ERR,
  nbody_step_scheduler_if.master bus
`ifdef NBODY_SCHED_STATS_EN
  ,
  output logic [31:0] STEP_CYCLES
`endif
);
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_PAIRS, S_DRAIN_F, S_INTEG, S_DRAIN_I, S_FINISH
  } state_t;

  localparam logic [6:0]       MAX_N   = 7'(MAX_BODIES);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_TWO = IDX_W'(2);
  localparam logic [OUT_W-1:0] CNT_ONE = OUT_W'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] n_q, n_in;
  logic [IDX_W-1:0] pair_i_q, pair_j_q, int_idx_q;
  logic [OUT_W-1:0] pair_cnt_q, int_cnt_q;
  logic             err_q, done_q;
  logic             pair_acc, int_acc, pair_last, pair_drained, int_drained;

  assign n_in = (NUM_BODIES > MAX_N) ? IDX_W'(MAX_N) : IDX_W'(NUM_BODIES);

  assign bus.PAIR_VALID = (state_q == S_PAIRS);
  assign bus.INT_VALID  = (state_q == S_INTEG);
  assign bus.PAIR_I     = pair_i_q;
  assign bus.PAIR_J     = pair_j_q;
  assign bus.INT_IDX    = int_idx_q;
  assign BUSY           = (state_q != S_IDLE);
  assign CLR_ACC        = (state_q == S_CLEAR);
  assign DONE           = done_q;
  assign ERR            = err_q;

  assign pair_acc  = bus.PAIR_VALID & bus.PAIR_READY;
  assign int_acc   = bus.INT_VALID & bus.INT_READY;
  assign pair_last = (pair_j_q == n_q) && (pair_i_q == n_q - IDX_ONE);
  // Drains exit as soon as the count will be zero next cycle, so a final DONE costs no extra cycle.
  assign pair_drained = (pair_cnt_q == '0) || ((pair_cnt_q == CNT_ONE) && bus.PAIR_DONE);
  assign int_drained  = (int_cnt_q == '0) || ((int_cnt_q == CNT_ONE) && bus.INT_DONE);

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (START) state_d = S_CLEAR;
      S_CLEAR: begin
        if (n_q >= IDX_TWO)      state_d = S_PAIRS;
        else if (n_q == IDX_ONE) state_d = S_INTEG;
        else                     state_d = S_FINISH;
      end
      S_PAIRS:   if (pair_acc && pair_last) state_d = S_DRAIN_F;
      S_DRAIN_F: if (pair_drained) state_d = S_INTEG;
      S_INTEG:   if (int_acc && (int_idx_q == n_q)) state_d = S_DRAIN_I;
      S_DRAIN_I: if (int_drained) state_d = S_FINISH;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      n_q       <= '0;
      pair_i_q  <= '0;
      pair_j_q  <= '0;
      int_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == S_FINISH);
      if ((state_q == S_IDLE) && START) n_q <= n_in;
      if (state_q == S_CLEAR) begin
        pair_i_q  <= IDX_ONE;
        pair_j_q  <= IDX_TWO;
        int_idx_q <= IDX_ONE;
      end
      // Lexicographic walk over i<j; row wrap restarts J just past the new I.
      if (pair_acc && !pair_last) begin
        if (pair_j_q == n_q) begin
          pair_i_q <= pair_i_q + IDX_ONE;
          pair_j_q <= pair_i_q + IDX_TWO;
        end else begin
          pair_j_q <= pair_j_q + IDX_ONE;
        end
      end
      if (int_acc && (int_idx_q != n_q)) int_idx_q <= int_idx_q + IDX_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pair_cnt_q <= '0;
      int_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      if (pair_acc && !bus.PAIR_DONE) begin
        pair_cnt_q <= pair_cnt_q + CNT_ONE;
      end else if (!pair_acc && bus.PAIR_DONE) begin
        if (pair_cnt_q == '0) err_q <= 1'b1;
        else                  pair_cnt_q <= pair_cnt_q - CNT_ONE;
      end
      if (int_acc && !bus.INT_DONE) begin
        int_cnt_q <= int_cnt_q + CNT_ONE;
      end else if (!int_acc && bus.INT_DONE) begin
        if (int_cnt_q == '0) err_q <= 1'b1;
        else                 int_cnt_q <= int_cnt_q - CNT_ONE;
      end
    end
  end

`ifdef NBODY_SCHED_STATS_EN
  logic [31:0] cyc_q, step_cycles_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cyc_q         <= '0;
      step_cycles_q <= '0;
    end else begin
      if ((state_q == S_IDLE) && START) cyc_q <= 32'd1;
      else if (state_q != S_IDLE)       cyc_q <= cyc_q + 32'd1;
      if (done_q) step_cycles_q <= cyc_q + 32'd1;
    end
  end

  assign STEP_CYCLES = step_cycles_q;
`endif
endmodule

// File: tb/tb_nbody_step_scheduler.sv
// tb/tb_nbody_step_scheduler.sv - randomized self-checking bench for nbody_step_scheduler
module tb_nbody_step_scheduler;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [6:0] NUM_BODIES = 7'd0;
  logic       BUSY, DONE, CLR_ACC, ERR;
`ifdef NBODY_SCHED_STATS_EN
  logic [31:0] STEP_CYCLES;
`endif

  nbody_step_scheduler_if #(.IDX_W(4)) bus ();

  nbody_step_scheduler #(.MAX_BODIES(10), .IDX_W(4), .OUT_W(7)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .NUM_BODIES(NUM_BODIES),
    .BUSY(BUSY), .DONE(DONE), .CLR_ACC(CLR_ACC), .ERR(ERR),
    .bus(bus)
`ifdef NBODY_SCHED_STATS_EN
    , .STEP_CYCLES(STEP_CYCLES)
`endif
  );

  always #10 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int unsigned ready_pct = 100;
  int          done_dly = 1;
  int          stall_left = 0;
  logic [3:0]  stall_i = 4'd0, stall_j = 4'd0;
  bit          inject_int_done = 1'b0;
  int          pair_due[$];
  int          int_due[$];

  logic [7:0] obs_pairs[$];
  int         obs_ints[$];
  int clr_cnt, clr_cyc, done_cnt, done_cyc, pvalid_cnt, ivalid_cnt;
  int hold_viol, int_pend_viol, stall_seen, pend_pair;
  int first_int_cyc, first_pair_cyc, last_pair_cyc, busy_rise;
  int start_cyc;
  bit got_done;

  // Force unit / integrator stand-in: READY policy and DONE pulses a fixed delay after each accept.
  initial begin : responder
    bus.PAIR_READY = 1'b0; bus.PAIR_DONE = 1'b0;
    bus.INT_READY  = 1'b0; bus.INT_DONE  = 1'b0;
    forever begin
      @(posedge CLK);
      cyc++;
      #2;
      bus.PAIR_DONE = (pair_due.size() > 0 && pair_due[0] == cyc);
      if (pair_due.size() > 0 && pair_due[0] == cyc) void'(pair_due.pop_front());
      bus.INT_DONE = (int_due.size() > 0 && int_due[0] == cyc) || inject_int_done;
      if (int_due.size() > 0 && int_due[0] == cyc) void'(int_due.pop_front());
      if (stall_left > 0 && bus.PAIR_VALID && bus.PAIR_I == stall_i && bus.PAIR_J == stall_j) begin
        bus.PAIR_READY = 1'b0;
        stall_left--;
      end else begin
        bus.PAIR_READY = ($urandom_range(99) < ready_pct);
      end
      bus.INT_READY = ($urandom_range(99) < ready_pct);
    end
  end

  bit prev_pstall, prev_istall, prev_busy;
  logic [3:0] prev_i, prev_j, prev_idx;

  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (RESET) begin
        pair_due.delete(); int_due.delete();
        prev_pstall = 0; prev_istall = 0; pend_pair = 0; prev_busy = 0;
      end else begin
        if (BUSY && !prev_busy) busy_rise = cyc;
        prev_busy = BUSY;
        if (CLR_ACC) begin clr_cnt++; clr_cyc = cyc; end
        if (DONE) begin done_cnt++; done_cyc = cyc; end
        if (bus.PAIR_VALID) pvalid_cnt++;
        if (bus.INT_VALID) begin
          ivalid_cnt++;
          if (first_int_cyc < 0) first_int_cyc = cyc;
        end
        if (prev_pstall && !(bus.PAIR_VALID && bus.PAIR_I == prev_i && bus.PAIR_J == prev_j)) hold_viol++;
        if (prev_istall && !(bus.INT_VALID && bus.INT_IDX == prev_idx)) hold_viol++;
        if (bus.PAIR_DONE) pend_pair--;
        if (bus.PAIR_VALID && bus.PAIR_READY) begin
          obs_pairs.push_back({bus.PAIR_I, bus.PAIR_J});
          pair_due.push_back(cyc + done_dly);
          pend_pair++;
          if (first_pair_cyc < 0) first_pair_cyc = cyc;
          last_pair_cyc = cyc;
        end
        if (bus.INT_VALID && pend_pair > 0) int_pend_viol++;
        if (bus.INT_VALID && bus.INT_READY) begin
          obs_ints.push_back(int'(bus.INT_IDX));
          int_due.push_back(cyc + done_dly);
        end
        if (bus.PAIR_VALID && !bus.PAIR_READY && bus.PAIR_I == stall_i && bus.PAIR_J == stall_j) stall_seen++;
        prev_pstall = bus.PAIR_VALID && !bus.PAIR_READY;
        prev_i = bus.PAIR_I; prev_j = bus.PAIR_J;
        prev_istall = bus.INT_VALID && !bus.INT_READY;
        prev_idx = bus.INT_IDX;
      end
    end
  end

  // Reference model: effective body count and the expected transfer sequences.
  function automatic int eff_n(int raw);
    return (raw > 10) ? 10 : raw;
  endfunction

  function automatic int pair_diffs(int n);
    logic [7:0] exp_q[$];
    int d = 0;
    for (int i = 1; i < n; i++)
      for (int j = i + 1; j <= n; j++) exp_q.push_back({4'(i), 4'(j)});
    if (exp_q.size() != obs_pairs.size()) d++;
    for (int k = 0; k < exp_q.size() && k < obs_pairs.size(); k++)
      if (exp_q[k] !== obs_pairs[k]) d++;
    return d;
  endfunction

  function automatic int int_diffs(int n);
    int d = 0;
    if (obs_ints.size() != n) d++;
    for (int k = 0; k < n && k < obs_ints.size(); k++)
      if (obs_ints[k] != k + 1) d++;
    return d;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_obs();
    obs_pairs.delete(); obs_ints.delete();
    clr_cnt = 0; clr_cyc = -1; done_cnt = 0; done_cyc = -1;
    pvalid_cnt = 0; ivalid_cnt = 0; hold_viol = 0; int_pend_viol = 0;
    stall_seen = 0; first_int_cyc = -1; first_pair_cyc = -1; last_pair_cyc = -1;
    busy_rise = -1;
  endtask

  task automatic reset_dut();
    START = 1'b0; inject_int_done = 1'b0; stall_left = 0;
    tick(); RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
  endtask

  task automatic start_step(int nb);
    tick();
    START = 1'b1;
    NUM_BODIES = 7'(nb);
    start_cyc = cyc;
    tick();
    START = 1'b0;
    NUM_BODIES = 7'($urandom_range(127));
  endtask

  task automatic wait_done(int budget, bit mid_starts, string name);
    got_done = 0;
    for (int k = 0; k < budget && !got_done; k++) begin
      if (DONE) got_done = 1;
      else begin
        START = (mid_starts && BUSY && $urandom_range(3) == 0);
        tick();
      end
    end
    START = 1'b0;
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL %s_timeout: DONE seen %0d required 1 within %0d cycles", name, got_done, budget);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0)          begin errors++; $display("FAIL reset_done: got %b want 0", DONE); end
    checks++; if (CLR_ACC !== 1'b0)       begin errors++; $display("FAIL reset_clr: got %b want 0", CLR_ACC); end
    checks++; if (bus.PAIR_VALID !== 1'b0) begin errors++; $display("FAIL reset_pvalid: got %b want 0", bus.PAIR_VALID); end
    checks++; if (bus.INT_VALID !== 1'b0)  begin errors++; $display("FAIL reset_ivalid: got %b want 0", bus.INT_VALID); end
    checks++; if (ERR !== 1'b0)           begin errors++; $display("FAIL reset_err: got %b want 0", ERR); end
    checks++; if ({bus.PAIR_I, bus.PAIR_J, bus.INT_IDX} !== 12'h000)
      begin errors++; $display("FAIL reset_idx: got %h want 000", {bus.PAIR_I, bus.PAIR_J, bus.INT_IDX}); end
`ifdef NBODY_SCHED_STATS_EN
    checks++; if (STEP_CYCLES !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d want 0", STEP_CYCLES); end
`endif
  endtask

  task automatic test_basic_n4();
    reset_dut(); clear_obs();
    ready_pct = 100; done_dly = 1;
    start_step(4);
    wait_done(200, 0, "basic");
    checks++; if (pair_diffs(4) != 0) begin errors++; $display("FAIL basic_pairs: got %0d pairs / %0d diffs want 6 / 0", obs_pairs.size(), pair_diffs(4)); end
    checks++; if (int_diffs(4) != 0)  begin errors++; $display("FAIL basic_ints: got %0d ints / %0d diffs want 4 / 0", obs_ints.size(), int_diffs(4)); end
    checks++; if (done_cnt != 1)       begin errors++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (ERR !== 1'b0)        begin errors++; $display("FAIL basic_err: got %b want 0", ERR); end
    checks++; if (busy_rise != start_cyc + 1) begin errors++; $display("FAIL basic_busy_rise: got %0d want %0d", busy_rise, start_cyc + 1); end
    checks++; if (clr_cyc != start_cyc + 1)   begin errors++; $display("FAIL basic_clr_cyc: got %0d want %0d", clr_cyc, start_cyc + 1); end
    checks++; if (first_pair_cyc != start_cyc + 2) begin errors++; $display("FAIL basic_pair_cyc: got %0d want %0d", first_pair_cyc, start_cyc + 2); end
    checks++; if (first_int_cyc != start_cyc + 9)  begin errors++; $display("FAIL basic_int_cyc: got %0d want %0d", first_int_cyc, start_cyc + 9); end
    checks++; if (done_cyc != start_cyc + 15)      begin errors++; $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc, start_cyc + 15); end
`ifdef NBODY_SCHED_STATS_EN
    checks++; if (STEP_CYCLES !== 32'd16) begin errors++; $display("FAIL basic_stats: got %0d want 16", STEP_CYCLES); end
`endif
  endtask

  task automatic test_stall_n3();
    reset_dut(); clear_obs();
    ready_pct = 100; done_dly = 1;
    stall_i = 4'd1; stall_j = 4'd3; stall_left = 5;
    start_step(3);
    wait_done(200, 0, "stall");
    checks++; if (pair_diffs(3) != 0) begin errors++; $display("FAIL stall_pairs: got %0d pairs / %0d diffs want 3 / 0", obs_pairs.size(), pair_diffs(3)); end
    checks++; if (stall_seen != 5)     begin errors++; $display("FAIL stall_hold_cycles: got %0d want 5", stall_seen); end
    checks++; if (hold_viol != 0)      begin errors++; $display("FAIL stall_hold_viol: got %0d want 0", hold_viol); end
    checks++; if (int_diffs(3) != 0)  begin errors++; $display("FAIL stall_ints: got %0d diffs want 0", int_diffs(3)); end
    stall_i = 4'd0; stall_j = 4'd0; stall_left = 0;
  endtask

  task automatic test_small_counts();
    reset_dut(); clear_obs();
    ready_pct = 100; done_dly = 1;
    start_step(0);
    wait_done(50, 0, "n0");
    checks++; if (clr_cnt != 1)     begin errors++; $display("FAIL n0_clr: got %0d want 1", clr_cnt); end
    checks++; if (pvalid_cnt != 0)  begin errors++; $display("FAIL n0_pvalid: got %0d want 0", pvalid_cnt); end
    checks++; if (ivalid_cnt != 0)  begin errors++; $display("FAIL n0_ivalid: got %0d want 0", ivalid_cnt); end
    checks++; if (done_cyc != clr_cyc + 2) begin errors++; $display("FAIL n0_done_cyc: got %0d want %0d", done_cyc, clr_cyc + 2); end
    clear_obs();
    start_step(1);
    wait_done(50, 0, "n1");
    checks++; if (obs_pairs.size() != 0) begin errors++; $display("FAIL n1_pairs: got %0d want 0", obs_pairs.size()); end
    checks++; if (int_diffs(1) != 0)     begin errors++; $display("FAIL n1_ints: got %0d ints want 1", obs_ints.size()); end
    checks++; if (done_cnt != 1)         begin errors++; $display("FAIL n1_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_clamp();
    reset_dut(); clear_obs();
    ready_pct = 60; done_dly = $urandom_range(1, 4);
    start_step(15);
    wait_done(3000, 1, "clamp");
    checks++; if (obs_pairs.size() != 45 || pair_diffs(10) != 0)
      begin errors++; $display("FAIL clamp_pairs: got %0d pairs / %0d diffs want 45 / 0", obs_pairs.size(), pair_diffs(10)); end
    checks++; if (int_diffs(10) != 0) begin errors++; $display("FAIL clamp_ints: got %0d ints want 10", obs_ints.size()); end
    checks++; if (clr_cnt != 1 || done_cnt != 1) begin errors++; $display("FAIL clamp_single_step: got clr %0d done %0d want 1 1", clr_cnt, done_cnt); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL clamp_idle_after: got %b want 0", BUSY); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL clamp_hold: got %0d want 0", hold_viol); end
  endtask

  task automatic test_drain_delay();
    int n;
    reset_dut(); clear_obs();
    ready_pct = 100; done_dly = 20;
    n = $urandom_range(2, 5);
    start_step(n);
    wait_done(1000, 0, "drain");
    checks++; if (int_pend_viol != 0) begin errors++; $display("FAIL drain_int_early: got %0d cycles want 0", int_pend_viol); end
    checks++; if (first_int_cyc != last_pair_cyc + 21) begin errors++; $display("FAIL drain_int_cyc: got %0d want %0d", first_int_cyc, last_pair_cyc + 21); end
    checks++; if (pair_diffs(n) != 0 || int_diffs(n) != 0) begin errors++; $display("FAIL drain_seq n=%0d: got %0d/%0d diffs want 0/0", n, pair_diffs(n), int_diffs(n)); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL drain_err: got %b want 0", ERR); end
  endtask

  task automatic test_spurious_done();
    reset_dut(); clear_obs();
    ready_pct = 100; done_dly = 1;
    tick(); inject_int_done = 1'b1;
    tick(); inject_int_done = 1'b0;
    tick(); tick();
    checks++; if (ERR !== 1'b1)  begin errors++; $display("FAIL spurious_err: got %b want 1", ERR); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL spurious_busy: got %b want 0", BUSY); end
    start_step(2);
    wait_done(200, 0, "sticky");
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL spurious_sticky: got %b want 1", ERR); end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_obs();
    ready_pct = 100; done_dly = 3;
    start_step(6);
    for (int k = 0; k < 50 && obs_pairs.size() < 3; k++) tick();
    checks++; if (bus.PAIR_VALID !== 1'b1) begin errors++; $display("FAIL midreset_in_pairs: got %b want 1", bus.PAIR_VALID); end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0)          begin errors++; $display("FAIL midreset_busy: got %b want 0", BUSY); end
    checks++; if (bus.PAIR_VALID !== 1'b0) begin errors++; $display("FAIL midreset_pvalid: got %b want 0", bus.PAIR_VALID); end
    checks++; if (ERR !== 1'b0)           begin errors++; $display("FAIL midreset_err: got %b want 0", ERR); end
    repeat (10) tick();
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL midreset_no_done: got %0d want 0", done_cnt); end
    clear_obs();
    n = $urandom_range(2, 8);
    start_step(n);
    wait_done(1000, 0, "after_reset");
    checks++; if (pair_diffs(n) != 0 || int_diffs(n) != 0 || ERR !== 1'b0 || done_cnt != 1)
      begin errors++; $display("FAIL midreset_clean_step n=%0d: got diffs %0d/%0d err %b done %0d want 0/0 0 1", n, pair_diffs(n), int_diffs(n), ERR, done_cnt); end
  endtask

  task automatic test_random_steps();
    int raw, n;
    reset_dut();
    for (int s = 0; s < 6; s++) begin
      clear_obs();
      raw = $urandom_range(0, 13);
      n = eff_n(raw);
      ready_pct = $urandom_range(30, 100);
      done_dly = $urandom_range(1, 6);
      start_step(raw);
      wait_done(3000, 1, "random");
      checks++; if (obs_pairs.size() != n * (n - 1) / 2 || pair_diffs(n) != 0)
        begin errors++; $display("FAIL random_pairs raw=%0d: got %0d pairs / %0d diffs want %0d / 0", raw, obs_pairs.size(), pair_diffs(n), n * (n - 1) / 2); end
      checks++; if (int_diffs(n) != 0) begin errors++; $display("FAIL random_ints raw=%0d: got %0d ints want %0d", raw, obs_ints.size(), n); end
      checks++; if (done_cnt != 1 || ERR !== 1'b0) begin errors++; $display("FAIL random_done_err: got done %0d err %b want 1 0", done_cnt, ERR); end
      checks++; if (hold_viol != 0 || int_pend_viol != 0) begin errors++; $display("FAIL random_rules: got hold %0d early %0d want 0 0", hold_viol, int_pend_viol); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_n4();
    test_stall_n3();
    test_small_counts();
    test_clamp();
    test_drain_delay();
    test_spurious_done();
    test_reset_mid();
    test_random_steps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
